// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths and the rotate-left sequencer state.
// Imported by every ALU operation unit and its interface.
package alu_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int CHUNK   = 4;

  typedef enum logic [1:0] {
    IDLE,
    ROT,
    FIN
  } rol_state_t;

endpackage

// File: rtl/alu_rol_seq_if.sv
// Start/busy/done handshake and operand/result bus of the rotate-left unit.
// The master side is the control unit; the slave side is the ALU unit.
interface alu_rol_seq_if;
  import alu_pkg::*;

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] R;
  logic             busy;
  logic             done;

  modport master (
    output start,
    output A,
    output B,
    input  R,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  A,
    input  B,
    output R,
    output busy,
    output done
  );

endinterface

// File: rtl/alu_rol_seq_step.sv
// One rotate-left retirement step: 4 positions while at least 4 remain,
// otherwise 1; holds when nothing remains so rem can never underflow.
module rol_step
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0]   acc,
  input  logic [SHAMT_W-1:0] rem,
  output logic [WIDTH-1:0]   acc_next,
  output logic [SHAMT_W-1:0] rem_next
);

  always_comb begin
    acc_next = acc;
    rem_next = rem;
    if (rem >= SHAMT_W'(CHUNK)) begin
      acc_next = {acc[WIDTH-CHUNK-1:0],
                  acc[WIDTH-1:WIDTH-CHUNK]};
      rem_next = rem - SHAMT_W'(CHUNK);
    end else if (rem != '0) begin
      acc_next = {acc[WIDTH-2:0], acc[WIDTH-1]};
      rem_next = rem - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_rol_seq.sv
// Multi-cycle rotate-left unit: IDLE captures A and B mod 32, ROT retires
// bit positions, FIN presents the result with a one-cycle done pulse.
module alu_rol_seq
  import alu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  alu_rol_seq_if.slave bus
);

  rol_state_t         state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]   r_q, r_d;

  logic [WIDTH-1:0]   step_acc;
  logic [SHAMT_W-1:0] step_rem;
  logic [SHAMT_W-1:0] b_amt;

  // Only the low 5 bits of B are an amount; the rest is don't-care.
  logic unused_b;
  assign unused_b = ^bus.B[WIDTH-1:SHAMT_W];
  assign b_amt    = bus.B[SHAMT_W-1:0];

  rol_step u_step (
    .acc      (acc_q),
    .rem      (rem_q),
    .acc_next (step_acc),
    .rem_next (step_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      r_q     <= r_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (b_amt != '0) ? ROT : FIN;
        end
      end
      ROT: begin
        if (step_rem == '0) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // R is written only on the edge that enters FIN.
  always_comb begin
    acc_d = acc_q;
    rem_d = rem_q;
    r_d   = r_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d = bus.A;
          rem_d = b_amt;
          if (b_amt == '0) begin
            r_d = bus.A;
          end
        end
      end
      ROT: begin
        acc_d = step_acc;
        rem_d = step_rem;
        if (step_rem == '0) begin
          r_d = step_acc;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == FIN);
    bus.R    = r_q;
  end

endmodule
